// File: rtl/scard_iso7816_rx.sv
// scard_iso7816_rx: ISO 7816-3 T=0 character receiver with parity NAK signalling
module scard_iso7816_rx #(
  parameter int ETU_W       = 16,
  parameter bit NAK_DEFAULT = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             io_i,
  output logic             io_drive_low_o,
  input  logic             enable_i,
  input  logic             nak_en_i,
  input  logic             conv_inv_i,
  input  logic [ETU_W-1:0] etu_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_parity_err_o,
  output logic             rx_frame_err_o,
  output logic             busy_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_GUARD, S_NAK, S_RECOVER} state_t;
  state_t r_state, w_next;
  logic r_s1, r_s2, r_s3;
  logic [ETU_W-1:0] r_cnt, r_etu, w_etu;
  logic r_conv, r_par, r_nak, r_valid, r_perr, r_ferr;
  logic [2:0] r_bit;
  logic [7:0] r_shift, r_data;
  logic w_edge, w_tick, w_bit, w_perr, w_nak_go, w_unused_nak_default;
  assign w_unused_nak_default = NAK_DEFAULT;
  assign w_etu    = (etu_i < ETU_W'(4)) ? ETU_W'(4) : etu_i;
  assign w_edge   = (r_state == S_IDLE) && enable_i && r_s3 && !r_s2;
  assign w_tick   = (r_cnt == '0);
  assign w_bit    = r_s2 ^ r_conv;
  assign w_perr   = r_par ^ w_bit;
  assign w_nak_go = (r_state == S_GUARD) && r_nak && (r_cnt == ETU_W'(1));
  assign io_drive_low_o  = (r_state == S_NAK);
  assign busy_o          = (r_state != S_IDLE);
  assign rx_data_o       = r_data;
  assign rx_valid_o      = r_valid;
  assign rx_parity_err_o = r_perr;
  assign rx_frame_err_o  = r_ferr;
  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) {r_s1, r_s2, r_s3} <= 3'b111;
    else         {r_s1, r_s2, r_s3} <= {io_i, r_s1, r_s2};
  // state register
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  // next state; NAK is entered one cycle early so the line is pulled low in the guard-sample cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_edge ? S_START : S_IDLE;
      S_START:   w_next = w_tick ? (r_s2 ? S_IDLE : S_DATA) : S_START;
      S_DATA:    w_next = (w_tick && r_bit == 3'd7) ? S_PARITY : S_DATA;
      S_PARITY:  w_next = w_tick ? S_GUARD : S_PARITY;
      S_GUARD:   w_next = w_nak_go ? S_NAK : (w_tick && !r_nak) ? S_IDLE : S_GUARD;
      S_NAK:     w_next = w_tick ? S_RECOVER : S_NAK;
      S_RECOVER: w_next = w_tick ? S_IDLE : S_RECOVER;
      default:   w_next = S_IDLE;
    endcase
    if (!enable_i) w_next = S_IDLE;
  end
  // sample timing, bit assembly, parity check and result strobes
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_cnt   <= '0;
      r_etu   <= ETU_W'(4);
      r_conv  <= 1'b0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_nak   <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_edge) begin
        r_cnt  <= (w_etu >> 1) - ETU_W'(1);
        r_etu  <= w_etu;
        r_conv <= conv_inv_i;
        r_bit  <= '0;
        r_par  <= 1'b0;
        r_nak  <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= (w_tick || w_nak_go) ? r_etu - ETU_W'(1) : r_cnt - ETU_W'(1);
      end
      if (r_state == S_DATA && w_tick) begin
        r_shift <= r_conv ? {r_shift[6:0], w_bit} : {w_bit, r_shift[7:1]};
        r_par   <= r_par ^ w_bit;
        r_bit   <= r_bit + 3'd1;
      end
      if (r_state == S_PARITY && w_tick) begin
        r_data  <= r_shift;
        r_nak   <= enable_i && w_perr && nak_en_i;
        r_valid <= enable_i && !(w_perr && nak_en_i);
        r_perr  <= enable_i && w_perr;
      end
      if (r_state == S_GUARD && w_tick && !r_nak) r_ferr <= enable_i && !r_s2;
    end
endmodule

// File: tb/tb_scard_iso7816_rx.sv
// tb_scard_iso7816_rx: randomized scoreboard bench for the T=0 character receiver
module tb_scard_iso7816_rx;
  logic clk_i = 0, reset_i = 1, io_i = 1, enable_i = 1, nak_en_i = 0, conv_inv_i = 0;
  logic [15:0] etu_i = 16;
  logic io_drive_low_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, busy_o;
  logic [7:0] rx_data_o;
  typedef struct {bit v; bit pe; bit fe; logic [7:0] d; int t;} st_t;
  typedef struct {int len; int dlen; int dst;} bt_t;
  st_t sq[$];
  bt_t bq[$];
  int n_tests = 0, n_fail = 0;
  scard_iso7816_rx #(.ETU_W(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .io_i(io_i), .io_drive_low_o(io_drive_low_o),
    .enable_i(enable_i), .nak_en_i(nak_en_i), .conv_inv_i(conv_inv_i), .etu_i(etu_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o(rx_frame_err_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // monitor: times every strobe and busy window relative to the start edge (busy rises at t=1)
  initial begin
    int cyc, bstart, dcnt, dst, t;
    bit pb;
    st_t e;
    bt_t b;
    cyc = 0; bstart = 0; dcnt = 0; dst = 0; pb = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (busy_o && !pb) begin bstart = cyc; dcnt = 0; end
      t = cyc - bstart + 1;
      if (io_drive_low_o) begin if (dcnt == 0) dst = t; dcnt++; end
      if (rx_valid_o || rx_parity_err_o || rx_frame_err_o) begin
        if (sq.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = sq.pop_front();
          chk("valid", int'(rx_valid_o), int'(e.v));
          chk("parity_err", int'(rx_parity_err_o), int'(e.pe));
          chk("frame_err", int'(rx_frame_err_o), int'(e.fe));
          chk("strobe_time", t, e.t);
          if (e.v) chk("data", int'(rx_data_o), int'(e.d));
        end
      end
      if (!busy_o && pb) begin
        if (bq.size() == 0) chk("unexpected_busy_end", 1, 0);
        else begin
          b = bq.pop_front();
          if (b.len >= 0) begin
            chk("busy_len", cyc - bstart, b.len);
            chk("nak_len", dcnt, b.dlen);
            if (b.dlen > 0) chk("nak_start", dst, b.dst);
          end
        end
      end
      pb = busy_o;
    end
  end
  // one character on the line; expectations come from the character-level rules
  task automatic send(input logic [7:0] d, input bit conv, input int etu, input bit bad,
                      input bit nak, input bit glow, input int abort_t, input int rst_t);
    int e, h;
    bit lv[11];
    bit p, nk;
    e = (etu < 4) ? 4 : etu;
    h = e / 2;
    nk = bad && nak;
    lv[0] = 0;
    for (int i = 0; i < 8; i++) lv[i+1] = (conv ? d[7-i] : d[i]) ^ conv;
    p = (^d) ^ bad;
    lv[9] = p ^ conv;
    lv[10] = !glow;
    conv_inv_i = conv;
    etu_i = etu[15:0];
    nak_en_i = nak;
    if (abort_t > 0) bq.push_back('{abort_t, 0, 0});
    else begin
      sq.push_back('{!nk, bad, 1'b0, d, h + 9*e + 1});
      if (glow && !nk) sq.push_back('{1'b0, 1'b0, 1'b1, 8'h00, h + 10*e + 1});
      bq.push_back('{(rst_t > 0) ? -1 : (nk ? h + 12*e - 1 : h + 10*e), nk ? e : 0, h + 10*e});
    end
    for (int k = 0; k < 13*e + 8; k++) begin
      @(negedge clk_i);
      io_i = (k < 11*e) ? lv[k/e] : 1'b1;
      if (abort_t > 0 && k == abort_t + 2) enable_i = 0;
      if (rst_t > 0 && k == rst_t + 2) begin
        chk("drive_before_reset", int'(io_drive_low_o), 1);
        #1 reset_i = 1;
        #1;
        chk("drive_after_reset", int'(io_drive_low_o), 0);
        chk("busy_after_reset", int'(busy_o), 0);
        chk("data_after_reset", int'(rx_data_o), 0);
      end
      if (rst_t > 0 && k == rst_t + 3) reset_i = 0;
    end
    enable_i = 1;
  endtask
  // stimulus
  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_drive", int'(io_drive_low_o), 0);
    chk("rst_data", int'(rx_data_o), 0);
    chk("rst_strobes", int'({rx_valid_o, rx_parity_err_o, rx_frame_err_o}), 0);
    reset_i = 0;
    repeat (5) @(negedge clk_i);
    send(8'h3B, 0, 16, 0, 0, 0, 0, 0);
    send(8'h3F, 1, 16, 0, 0, 0, 0, 0);
    send(8'h3B, 0, 16, 1, 1, 0, 0, 0);
    send(8'h3B, 0, 16, 1, 0, 0, 0, 0);
    bq.push_back('{8, 0, 0});
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      io_i = (k < 3) ? 1'b0 : 1'b1;
    end
    send(8'h3B, 0, 16, 0, 0, 0, 0, 0);
    send(8'h3B, 0, 16, 0, 0, 1, 0, 0);
    send(8'hA5, 0, 16, 0, 0, 0, 60, 0);
    send(8'h3B, 0, 16, 1, 1, 0, 0, 175);
    send(8'hC3, 1, 2, 0, 0, 0, 0, 0);
    for (int n = 0; n < 24; n++)
      send(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, 0, 0);
    repeat (10) @(negedge clk_i);
    chk("strobe_queue_empty", sq.size(), 0);
    chk("busy_queue_empty", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
